dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shared data-memory arbiter for the multicore processor. Sits between NCORES core instances and the single `ram_data` instance, granting the memory port to one core per transaction using round-robin priority. Each core issues a held read or write request and stalls until a one-cycle acknowledge; the arbiter sequences the memory strobes and returns read data.

## Interface

- `NCORES`, 2: number of requesting cores (2–8).
- `ADDR_W`, 16: data-memory address width.
- `DATA_W`, 16: data word width.
- `RD_LAT`, 1: `ram_data` read latency in cycles, from `mem_rd` sampled to `mem_rdata` valid (1–3).

- `clk` in 1: single clock; all state on the rising edge. One clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `core_rd` in NCORES: per-core read request, level, held until ack.
- `core_wr` in NCORES: per-core write request, level, held until ack.
- `core_addr` in NCORES*ADDR_W: packed per-core address; core i at bits [i*ADDR_W +: ADDR_W].
- `core_wdata` in NCORES*DATA_W: packed per-core write data, same packing.
- `core_ack` out NCORES: one-hot, single-cycle transaction-complete pulse.
- `core_rdata` out DATA_W: read data broadcast to all cores; valid when the reading core's ack is high.
- `mem_addr` out ADDR_W: address to `ram_data`.
- `mem_wdata` out DATA_W: write data to `ram_data`.
- `mem_rdata` in DATA_W: read data from `ram_data`.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.

## Operation

- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: request vector `req[i] = core_rd[i] | core_wr[i]`. If any bit is set, pick the winner g by round-robin starting at `last+1` mod NCORES. Latch g, `core_addr[g]`, `core_wdata[g]`, and op (write if `core_wr[g]`, else read) into registers. Go to ACCESS.
- ACCESS (1 cycle): drive `mem_addr`/`mem_wdata` from the latched registers; `mem_wr`=1 for writes, `mem_rd`=1 for reads. Writes go to RESP; reads go to WAIT.
- WAIT (RD_LAT cycles, counter): on the final WAIT cycle, capture `mem_rdata` into `core_rdata`. Go to RESP.
- RESP (1 cycle): `core_ack[g]`=1, `last`←g. Go to IDLE.
- `core_rd` and `core_wr` both high on one core is illegal. The arbiter treats it as a write.
- A core deasserts its request in the cycle after its ack. Requests from other cores stay pending across transactions.
- `core_rdata` holds its value until the next read capture. Writes do not change it.
- Memory strobes are never asserted outside ACCESS. `mem_addr` and `mem_wdata` hold their last values.

## Timing

- All outputs are registered.
- Reset values: state IDLE; `last`=NCORES-1, so core 0 wins first; `core_ack`=0; `core_rdata`=0; `mem_rd`=`mem_wr`=0; `mem_addr`=0; `mem_wdata`=0.
- Write latency: request sampled in IDLE at edge k, ACCESS in cycle k+1, ack in cycle k+2.
- Read latency: ACCESS in cycle k+1, WAIT for RD_LAT cycles, ack in cycle k+2+RD_LAT with data.
- Minimum turnaround: 3 cycles per write and 3+RD_LAT cycles per read, because one IDLE cycle separates consecutive grants.
- Simultaneous requests: exactly one grant per IDLE. Under full load each core is served at least once every NCORES transactions.
- Requests that arrive during ACCESS, WAIT or RESP are not observed until the next IDLE.
- Reset asserted mid-transaction: immediate return to reset values. An in-flight write may or may not have committed. No ack is issued.

## Structure

- Package `dmem_arb_pkg`: state enum `arb_state_t` {IDLE, ACCESS, WAIT, RESP}, default `ADDR_W`/`DATA_W` constants.
- Sub-module `rr_picker`: combinational. Inputs are the req vector and `last`; outputs are the grant index and a valid flag. Parameterised by NCORES.
- Top-level FSM, latches, WAIT counter, and the `last` register live in `dmem_arbiter`. It replaces the direct core-to-`ram_data` connection in the multicore top.

## Test plan

- Reset, then core 0 writes addr 0x0010 data 0xBEEF -> `mem_wr`=1 for exactly 1 cycle with addr 0x0010 and data 0xBEEF; `core_ack[0]` 2 cycles after the request is sampled.
- Core 1 reads 0x0010 with RD_LAT=1 -> `mem_rd` 1 cycle, `core_ack[1]` 3 cycles after the request is sampled, `core_rdata`=0xBEEF.
- Cores 0 and 1 request simultaneously from reset -> core 0 is granted first, core 1 next; core 1's ack lands 3 or 3+RD_LAT cycles later.
- NCORES=4, all cores hold write requests continuously -> grant order 0,1,2,3,0,… with no core skipped or repeated.
- Core 2 asserts `core_rd` and `core_wr` together with wdata 0x1234 -> treated as a write, `mem_wr`=1, `mem_rd`=0.
- `rstn` pulsed low during WAIT -> all outputs return to reset values asynchronously, no `core_ack`, and the next request is served normally.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state type and default widths for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin choice of the first requester after last
module rr_picker #(
    parameter int NCORES = 2,
    localparam int IW = $clog2(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [IW-1:0]     last,
    output logic [IW-1:0]     grant,
    output logic              valid
);
    logic [IW-1:0] idx;

    // Scanning from the farthest offset down lets the nearest requester win.
    always_comb begin
        grant = '0;
        idx = '0;
        for (int k = NCORES; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NCORES);
            if (req[idx]) grant = idx;
        end
    end

    assign valid = |req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: grants the single ram_data port to one core per transaction,
// round-robin, sequencing the memory strobes and returning read data.
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int NCORES = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1,
    localparam int IW = $clog2(NCORES)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NCORES-1:0]        core_rd,
    input  logic [NCORES-1:0]        core_wr,
    input  logic [NCORES*ADDR_W-1:0] core_addr,
    input  logic [NCORES*DATA_W-1:0] core_wdata,
    output logic [NCORES-1:0]        core_ack,
    output logic [DATA_W-1:0]        core_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     mem_rd,
    output logic                     mem_wr
);
    arb_state_t    state;
    logic [IW-1:0] g;
    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic          pick_ok;
    logic          op_wr;
    logic [1:0]    cnt;

    rr_picker #(.NCORES(NCORES)) u_pick (
        .req(core_rd | core_wr),
        .last(last),
        .grant(pick),
        .valid(pick_ok)
    );

    // mem_addr/mem_wdata double as the latched request; strobes are loaded on
    // the grant edge so they are high exactly during ACCESS.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            g <= '0;
            last <= IW'(NCORES - 1);
            op_wr <= 1'b0;
            cnt <= '0;
            core_ack <= '0;
            core_rdata <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
        end else begin
            core_ack <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            case (state)
                IDLE: if (pick_ok) begin
                    g <= pick;
                    op_wr <= core_wr[pick];
                    mem_addr <= core_addr[pick*ADDR_W +: ADDR_W];
                    mem_wdata <= core_wdata[pick*DATA_W +: DATA_W];
                    mem_wr <= core_wr[pick];
                    mem_rd <= !core_wr[pick];
                    state <= ACCESS;
                end
                ACCESS: begin
                    cnt <= '0;
                    if (op_wr) core_ack[g] <= 1'b1;
                    state <= op_wr ? RESP : WAIT;
                end
                WAIT: if (cnt == 2'(RD_LAT - 1)) begin
                    core_rdata <= mem_rdata;
                    core_ack[g] <= 1'b1;
                    state <= RESP;
                end else begin
                    cnt <= cnt + 2'd1;
                end
                RESP: begin
                    last <= g;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized bench against a transaction-level arbiter model
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int N = 4, AW = 16, DW = 16, RL = 2;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic [N-1:0]    core_rd = '0;
    logic [N-1:0]    core_wr = '0;
    logic [N*AW-1:0] core_addr = '0;
    logic [N*DW-1:0] core_wdata = '0;
    logic [N-1:0]    core_ack;
    logic [DW-1:0]   core_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd, mem_wr;

    logic [DW-1:0] ram [256];
    logic [DW-1:0] pipe [RL];
    logic [DW-1:0] shadow [256];
    logic [AW-1:0] wlist [$];

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = -100, ack_cyc = -100, idle_cyc = 0, mg = 0, mlast = N - 1;
    int drop_cyc [N];
    bit mwr = 1'b0;
    logic [AW-1:0] maddr = '0;
    logic [DW-1:0] mdata = '0, rd_val = '0, exp_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk(clk), .rstn(rstn), .core_rd(core_rd), .core_wr(core_wr),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
        .core_rdata(core_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    // ram_data stand-in: data appears RL cycles after a sampled read strobe
    assign mem_rdata = pipe[RL-1];
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr[7:0]] <= mem_wdata;
        pipe[0] <= mem_rd ? ram[mem_addr[7:0]] : 'x;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic req(input int i, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_rd[i] = rd;
        core_wr[i] = wr;
        core_addr[i*AW +: AW] = a;
        core_wdata[i*DW +: DW] = d;
    endtask

    // One clock: the model decides what the arbiter grants at the coming edge,
    // then the outputs of the next cycle are compared at the falling edge.
    task automatic cycle();
        logic [N-1:0] pend, ea;
        bit found;
        int j;
        pend = core_rd | core_wr;
        found = 1'b0;
        if (cyc >= idle_cyc && pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                j = (mlast + k) % N;
                if (!found && pend[j[1:0]]) begin
                    mg = j;
                    found = 1'b1;
                end
            end
            mlast = mg;
            mwr = core_wr[mg[1:0]];
            maddr = core_addr[mg*AW +: AW];
            mdata = core_wdata[mg*DW +: DW];
            if (mwr) begin
                shadow[maddr[7:0]] = mdata;
                wlist.push_back(maddr);
            end else begin
                rd_val = shadow[maddr[7:0]];
            end
            acc_cyc = cyc + 1;
            ack_cyc = cyc + 2 + (mwr ? 0 : RL);
            idle_cyc = ack_cyc + 1;
        end
        @(negedge clk);
        cyc++;
        if (cyc == ack_cyc && !mwr) exp_rdata = rd_val;
        ea = '0;
        if (cyc == ack_cyc) ea[mg[1:0]] = 1'b1;
        check("core_ack", core_ack, ea);
        check("mem_wr", mem_wr, cyc == acc_cyc && mwr);
        check("mem_rd", mem_rd, cyc == acc_cyc && !mwr);
        if (cyc == acc_cyc) check("mem_addr", mem_addr, maddr);
        if (cyc == acc_cyc && mwr) check("mem_wdata", mem_wdata, mdata);
        check("core_rdata", core_rdata, exp_rdata);
        if (cyc == ack_cyc) begin
            core_rd[mg[1:0]] = 1'b0;
            core_wr[mg[1:0]] = 1'b0;
            drop_cyc[mg] = cyc;
        end
    endtask

    // Asynchronous reset pulse, asserted away from any clock edge.
    task automatic do_reset();
        #2 rstn = 1'b0;
        core_rd = '0;
        core_wr = '0;
        #1;
        check("rst_ack", core_ack, '0);
        check("rst_rdata", core_rdata, '0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        repeat (2) @(negedge clk);
        cyc += 2;
        rstn = 1'b1;
        mlast = N - 1;
        acc_cyc = -100;
        ack_cyc = -100;
        idle_cyc = cyc;
        mwr = 1'b0;
        maddr = '0;
        mdata = '0;
        exp_rdata = '0;
        for (int i = 0; i < N; i++) drop_cyc[i] = -10;
    endtask

    task automatic auto_req(input int pct, input bit wr_only);
        for (int i = 0; i < N; i++)
            if (!(core_rd[i] | core_wr[i]) && cyc >= drop_cyc[i] + 2 && int'($urandom_range(99)) < pct) begin
                if (wr_only || wlist.size() == 0 || $urandom_range(1) == 1)
                    req(i, wr_only ? 1'b0 : 1'($urandom_range(1)), 1'b1, AW'($urandom_range(31)), DW'($urandom));
                else
                    req(i, 1'b1, 1'b0, wlist[$urandom_range(wlist.size() - 1)], DW'($urandom));
            end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && ((core_rd | core_wr) != '0 || cyc < idle_cyc); t++) cycle();
        check("drain", core_rd | core_wr, '0);
    endtask

    initial begin
        int prev, idx, guard;
        for (int i = 0; i < N; i++) drop_cyc[i] = -10;
        do_reset();
        req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        repeat (6) cycle();
        req(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        repeat (8) cycle();
        check("read_back", core_rdata, 16'hBEEF);

        do_reset();
        req(0, 1'b0, 1'b1, 16'h0020, 16'h1111);
        req(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        repeat (12) cycle();
        req(2, 1'b1, 1'b1, 16'h0030, 16'h1234);
        repeat (6) cycle();
        req(3, 1'b1, 1'b0, 16'h0030, 16'h0000);
        repeat (8) cycle();
        check("both_is_write", core_rdata, 16'h1234);

        do_reset();
        prev = N - 1;
        for (int t = 0; t < 160; t++) begin
            auto_req(100, 1'b1);
            cycle();
            if (core_ack != '0) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (core_ack[i]) idx = i;
                check("rr_order", idx, (prev + 1) % N);
                prev = idx;
            end
        end
        drain();

        req(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        guard = 0;
        while (!(cyc == acc_cyc + 1 && !mwr) && guard < 20) begin
            cycle();
            guard++;
        end
        check("reach_wait", cyc - acc_cyc, 1);
        do_reset();
        repeat (3) cycle();
        req(2, 1'b1, 1'b0, 16'h0010, 16'h0000);
        repeat (8) cycle();

        for (int t = 0; t < 1500; t++) begin
            auto_req(35, 1'b0);
            cycle();
        end
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
